dip_bank_loader: RTL and testbench
==================================

# dip_bank_loader

Parametrised DIP-switch and game-mode loader that sits between `hps_io` and the game-specific input mapping in the `emu` top level. It captures the HPS DIP download stream into a shadow bank and commits it atomically to a live bank when the download ends, so game logic never sees a half-written switch set. It also latches the game-mode byte from its own download index, applying the same commit rule. It reports validity, a one-cycle change pulse, and out-of-range write overflow.

## Interface
- `NUM_BYTES`, 8: DIP bank depth in bytes (1..32).
- `DIP_INDEX`, 8'd254: `ioctl_index` value for the DIP download.
- `MODE_INDEX`, 8'd1: `ioctl_index` value whose bytes carry the game mode.
- `MODE_W`, 2: game-mode width, taken from `ioctl_dout[MODE_W-1:0]`.
- `ADDR_W`, 25: `ioctl_addr` width.
- `RESET_VALUE`, '0: `NUM_BYTES*8`-bit live-bank value after reset.

Ports:
- `clk`  in  1  system clock (`clk_sys`); single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  download in progress.
- `ioctl_wr`  in  1  byte write strobe.
- `ioctl_index`  in  8  download target index.
- `ioctl_addr`  in  ADDR_W  byte address within the download.
- `ioctl_dout`  in  8  byte data.
- `sw_out`  out  NUM_BYTES*8  live bank; byte k occupies bits [8k+7:8k].
- `sw_valid`  out  1  sticky; set at the first commit that wrote at least one byte.
- `sw_changed`  out  1  one-cycle pulse when a commit alters `sw_out`.
- `game_mode`  out  MODE_W  live game mode.
- `mode_valid`  out  1  sticky; set at the first mode commit.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `overflow`  out  1  sticky; a DIP write hit an address ≥ NUM_BYTES.

## Operation
- FSM states: IDLE, LOAD_DIP, LOAD_MODE, COMMIT.
- Rising-edge detect: `dl_rise = ioctl_download & ~dl_q`, where `dl_q` is `ioctl_download` registered.
- IDLE transitions:
  - On `dl_rise` with index == DIP_INDEX, go to LOAD_DIP.
  - On `dl_rise` with index == MODE_INDEX, go to LOAD_MODE.
  - In both cases, clear the write mask `wmask[NUM_BYTES-1:0]` and `mode_hit`.
  - A download already in progress when reset releases is ignored until its next rising edge.
- LOAD_DIP writes:
  - `ioctl_wr` with `ioctl_addr < NUM_BYTES`: `shadow[addr] <= dout` and `wmask[addr] <= 1`.
  - Address ≥ NUM_BYTES (full ADDR_W compare, no truncation): data is dropped and `overflow <= 1`.
  - A repeated address keeps the last byte written.
- LOAD_MODE writes: `ioctl_wr` sets `mode_shadow <= dout[MODE_W-1:0]` and `mode_hit <= 1`. The last byte written wins.
- Writes are accepted in LOAD_* whenever `ioctl_wr` is high, including the cycle in which `ioctl_download` is sampled low.
- Exit from LOAD_*:
  - `ioctl_download` sampled low: go to COMMIT.
  - `ioctl_index` changes while still downloading: abort to IDLE with no commit; shadow contents are discarded.
- COMMIT (exactly one cycle):
  - Each byte k with `wmask[k]` set: `live[k] <= shadow[k]`. Unwritten bytes keep their value.
  - If `mode_hit`: `game_mode <= mode_shadow` and `mode_valid <= 1`.
  - `sw_changed <= 1` iff any committed live byte differs from its previous value. A mode change does not raise `sw_changed`.
  - `sw_valid <= 1` iff `|wmask`.
  - Next state: IDLE.
- An empty download (no writes) commits nothing and leaves `sw_valid` unchanged.
- Reset values: `sw_out = RESET_VALUE`; every other output is 0; FSM in IDLE. Shadow, mask and `dl_q` are cleared.
- Reset asserted mid-load: all state is lost, no commit occurs, and the live bank returns to RESET_VALUE.

## Timing
- `ioctl_download` rises at edge E0 (seen in `dl_q`): the FSM enters LOAD_* at E0 and `busy` is high from E0.
- A write sampled at edge N updates shadow at N. It is not visible on `sw_out` until commit.
- `ioctl_download` sampled low at edge M: FSM enters COMMIT at M.
- At M+1: `sw_out`/`game_mode` update, `sw_changed` goes high for the cycle M+1..M+2, FSM is IDLE, and `busy` drops.
- Latency from the last download-high cycle to updated `sw_out` is 2 edges.
- A new `dl_rise` sampled while in COMMIT is ignored. Downloads are separated by at least two cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then DIP download (idx 254) writing addr0=0x1B and addr7=0xA5 → after commit, `sw_out[7:0]`=0x1B, `sw_out[63:56]`=0xA5, other bytes 0; `sw_valid`=1; `sw_changed` pulses exactly one cycle, 2 edges after download falls.
- Repeat the identical download → `sw_out` is unchanged and `sw_changed` stays 0. Then write only addr3=0x40 → only byte 3 changes and `sw_changed` pulses.
- Write addr 8 and addr 0x100000 (NUM_BYTES=8) → `overflow`=1 and `sw_out` is untouched; a valid write in the same download still commits.
- Mode download (idx 1) writing 0x02 then 0x03 → `game_mode`=3 and `mode_valid`=1; `sw_out` and `sw_changed` are unaffected.
- DIP download aborted by an index change to 0 mid-stream → no commit and `sw_out` keeps its old value. Reset pulsed mid-download with `ioctl_download` still high → `sw_out`=RESET_VALUE, later writes in that download are ignored, and `busy` stays 0.
- Download of zero writes → after commit, `sw_valid` is unchanged (0 after reset) and `sw_changed`=0.

Source files
------------

// File: rtl/dip_bank_loader.sv
// DIP-switch / game-mode loader: captures the HPS download stream into a shadow
// bank and commits it to the live bank in one cycle when the download ends.
module dip_bank_loader #(
  parameter int                     NUM_BYTES   = 8,
  parameter logic [7:0]             DIP_INDEX   = 8'd254,
  parameter logic [7:0]             MODE_INDEX  = 8'd1,
  parameter int                     MODE_W      = 2,
  parameter int                     ADDR_W      = 25,
  parameter logic [NUM_BYTES*8-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_index,
  input  logic [ADDR_W-1:0]        ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic [NUM_BYTES*8-1:0]   sw_out,
  output logic                     sw_valid,
  output logic                     sw_changed,
  output logic [MODE_W-1:0]        game_mode,
  output logic                     mode_valid,
  output logic                     busy,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, LOAD_DIP, LOAD_MODE, COMMIT} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_dl_q;
  logic                     r_armed;
  logic [7:0]               r_idx;
  logic [7:0]               r_shadow [NUM_BYTES];
  logic [NUM_BYTES-1:0]     r_wmask;
  logic [MODE_W-1:0]        r_mode_shadow;
  logic                     r_mode_hit;
  logic [NUM_BYTES*8-1:0]   r_live;
  logic                     r_sw_valid;
  logic                     r_sw_changed;
  logic [MODE_W-1:0]        r_game_mode;
  logic                     r_mode_valid;
  logic                     r_busy;
  logic                     r_overflow;

  logic                     w_dl_rise;
  logic                     w_start;
  logic                     w_abort;
  logic                     w_wr_en;
  logic                     w_diff;

  // r_armed keeps a download that was already running at reset release from
  // being mistaken for a fresh rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_dl_rise   = ioctl_download & ~r_dl_q & r_armed;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dl_rise && ioctl_index == DIP_INDEX) begin
          w_state_nxt = LOAD_DIP;
          w_start     = 1'b1;
        end else if (w_dl_rise && ioctl_index == MODE_INDEX) begin
          w_state_nxt = LOAD_MODE;
          w_start     = 1'b1;
        end
      end
      LOAD_DIP, LOAD_MODE: begin
        w_abort = ioctl_download && (ioctl_index != r_idx);
        w_wr_en = ioctl_wr && !w_abort;
        if (!ioctl_download)
          w_state_nxt = COMMIT;
        else if (w_abort)
          w_state_nxt = IDLE;
      end
      COMMIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_diff = 1'b0;
    for (int k = 0; k < NUM_BYTES; k++)
      if (r_wmask[k] && (r_shadow[k] != r_live[8*k +: 8]))
        w_diff = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dl_q        <= 1'b0;
      r_armed       <= 1'b0;
      r_idx         <= '0;
      for (int k = 0; k < NUM_BYTES; k++) r_shadow[k] <= '0;
      r_wmask       <= '0;
      r_mode_shadow <= '0;
      r_mode_hit    <= 1'b0;
      r_live        <= RESET_VALUE;
      r_sw_valid    <= 1'b0;
      r_sw_changed  <= 1'b0;
      r_game_mode   <= '0;
      r_mode_valid  <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_dl_q       <= ioctl_download;
      r_sw_changed <= 1'b0;
      if (!ioctl_download) r_armed <= 1'b1;

      if (w_start) begin
        r_wmask    <= '0;
        r_mode_hit <= 1'b0;
        r_idx      <= ioctl_index;
      end

      if (w_wr_en && r_state == LOAD_DIP) begin
        // Full-width compare so high address bits never alias into the bank.
        if (ioctl_addr >= ADDR_W'(NUM_BYTES)) begin
          r_overflow <= 1'b1;
        end else begin
          for (int k = 0; k < NUM_BYTES; k++) begin
            if (ioctl_addr == ADDR_W'(k)) begin
              r_shadow[k] <= ioctl_dout;
              r_wmask[k]  <= 1'b1;
            end
          end
        end
      end

      if (w_wr_en && r_state == LOAD_MODE) begin
        r_mode_shadow <= ioctl_dout[MODE_W-1:0];
        r_mode_hit    <= 1'b1;
      end

      if (r_state == COMMIT) begin
        for (int k = 0; k < NUM_BYTES; k++)
          if (r_wmask[k]) r_live[8*k +: 8] <= r_shadow[k];
        if (r_mode_hit) begin
          r_game_mode  <= r_mode_shadow;
          r_mode_valid <= 1'b1;
        end
        r_sw_changed <= w_diff;
        if (|r_wmask) r_sw_valid <= 1'b1;
      end
    end
  end

  assign sw_out     = r_live;
  assign sw_valid   = r_sw_valid;
  assign sw_changed = r_sw_changed;
  assign game_mode  = r_game_mode;
  assign mode_valid = r_mode_valid;
  assign busy       = r_busy;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_dip_bank_loader.sv
// Scoreboard bench for dip_bank_loader: each download pushes its expected outputs,
// and a monitor compares them whenever busy falls.
module tb_dip_bank_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [63:0] sw_out;
  logic        sw_valid;
  logic        sw_changed;
  logic [1:0]  game_mode;
  logic        mode_valid;
  logic        busy;
  logic        overflow;

  dip_bank_loader dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .sw_out        (sw_out),
    .sw_valid      (sw_valid),
    .sw_changed    (sw_changed),
    .game_mode     (game_mode),
    .mode_valid    (mode_valid),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sw;
    logic        valid;
    logic        changed;
    logic [1:0]  mode;
    logic        mvalid;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [24:0] wa[$];
  logic [7:0]  wd[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] sw, input logic v, input logic c,
                      input logic [1:0] m, input logic mv, input logic ov);
    exp_t e;
    e.sw = sw; e.valid = v; e.changed = c; e.mode = m; e.mvalid = mv; e.ovf = ov;
    sb_q.push_back(e);
  endtask

  // Full download: rise, one write per queued entry, fall, then settle.
  task automatic download(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    while (wa.size() > 0) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = wa.pop_front();
      ioctl_dout = wd.pop_front();
      tick();
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    wa.push_back(a);
    wd.push_back(d);
  endtask

  // Monitor: a busy falling edge marks the end of a transaction.
  logic prev_busy = 1'b0;
  logic after_pop = 1'b0;
  always @(negedge clk) begin
    if (after_pop) chk("sw_changed_width", 64'(sw_changed), 64'd0);
    after_pop = 1'b0;
    if (prev_busy && !busy) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_txn: got busy fall expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        pops++;
        chk("sw_out",     sw_out,             e.sw);
        chk("sw_valid",   64'(sw_valid),      64'(e.valid));
        chk("sw_changed", 64'(sw_changed),    64'(e.changed));
        chk("game_mode",  64'(game_mode),     64'(e.mode));
        chk("mode_valid", 64'(mode_valid),    64'(e.mvalid));
        chk("overflow",   64'(overflow),      64'(e.ovf));
        after_pop = 1'b1;
      end
    end
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_sw_out",  sw_out, 64'd0);
    chk("rst_flags",   64'({sw_valid, sw_changed, game_mode, mode_valid, busy, overflow}), 64'd0);
    tick();

    push(64'hA500_0000_0000_001B, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    wr(25'd0, 8'h1B); wr(25'd7, 8'hA5);
    download(8'd254);

    push(64'hA500_0000_0000_001B, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    wr(25'd0, 8'h1B); wr(25'd7, 8'hA5);
    download(8'd254);

    push(64'hA500_0000_4000_001B, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    wr(25'd3, 8'h40);
    download(8'd254);

    push(64'hA500_0000_4000_771B, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    wr(25'd8, 8'hFF); wr(25'h100000, 8'hEE); wr(25'd1, 8'h77);
    download(8'd254);

    push(64'hA500_0000_4000_771B, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1);
    wr(25'd0, 8'h02); wr(25'd0, 8'h03);
    download(8'd1);

    // Abort: index changes mid-stream, shadow byte 2 must never reach sw_out.
    push(64'hA500_0000_4000_771B, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1);
    ioctl_index = 8'd254; ioctl_download = 1'b1; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd2; ioctl_dout = 8'h55; tick();
    ioctl_wr = 1'b0; ioctl_index = 8'd0; tick();
    ioctl_download = 1'b0; repeat (4) tick();
    chk("abort_hold", sw_out, 64'hA500_0000_4000_771B);

    // Reset in the middle of a download with download held high.
    push(64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    ioctl_index = 8'd254; ioctl_download = 1'b1; tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h11; tick();
    ioctl_wr = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h22; tick();
      chk("rst_mid_busy", 64'(busy), 64'd0);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; repeat (4) tick();
    chk("rst_mid_sw_out", sw_out, 64'd0);
    chk("rst_mid_busy_end", 64'(busy), 64'd0);

    push(64'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    download(8'd254);

    repeat (4) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("txn_count", 64'(pops), 64'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
